// File: rtl/dsp_stream_driver.sv
// Master-end driver for the systolic-array stream link: streams operand beats
// from a 1-cycle-latency buffer and captures result beats into a result buffer.
module dsp_stream_driver #(
  parameter int BW      = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int WORD_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     in_beats,
  input  logic [CNT_W-1:0]     out_beats,
  output logic                 busy,
  output logic                 finish,
  output logic                 status_done,
  output logic                 status_err,
  output logic                 rd_en,
  output logic [CNT_W-1:0]     rd_addr,
  input  logic [BW*WORD_W-1:0] rd_data,
  output logic                 wr_en,
  output logic [CNT_W-1:0]     wr_addr,
  output logic [BW*WORD_W-1:0] wr_data,
  output logic                 in_valid,
  output logic [BW*WORD_W-1:0] in_stream,
  output logic                 out_ready,
  input  logic                 in_ready,
  input  logic                 out_valid,
  input  logic [BW*WORD_W-1:0] out_stream,
  input  logic                 done,
  input  logic                 err
);

  localparam int DW   = BW * WORD_W;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] in_beats_q, out_beats_q;
  logic [CNT_W-1:0] rd_cnt, sent_cnt, cap_cnt;
  logic             rd_pend;
  logic [DW-1:0]    fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ;
  logic             sticky_done;
  logic [TO_W-1:0]  to_cnt;
  logic             active, pop, push, room, timeout_hit, abort;

  always_comb begin
    state_n     = state;
    active      = (state == STREAM) || (state == DRAIN);
    timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT));
    abort       = active && (err || timeout_hit);
    in_valid    = (state == STREAM) && (occ != 2'd0);
    pop         = in_valid && in_ready;
    push        = rd_pend && (state == STREAM);
    // Counting the in-flight read keeps the 2-entry FIFO from ever overflowing.
    room        = ({1'b0, occ} + {2'b0, rd_pend}) < (3'd2 + {2'b0, pop});
    rd_en       = (state == STREAM) && (rd_cnt < in_beats_q) && room;
    out_ready   = active && (cap_cnt < out_beats_q);
    wr_en       = out_valid && out_ready;
    wr_data     = wr_en ? out_stream : '0;
    in_stream   = in_valid ? fifo_mem[rd_ptr] : '0;
    rd_addr     = rd_cnt;
    wr_addr     = cap_cnt;
    busy        = active;
    finish      = (state == FIN);
    case (state)
      IDLE:    if (start) state_n = STREAM;
      STREAM: begin
        if (abort) state_n = FIN;
        else if (sent_cnt == in_beats_q) state_n = DRAIN;
      end
      DRAIN: begin
        if (abort) state_n = FIN;
        else if ((cap_cnt == out_beats_q) && (sticky_done || done)) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_beats_q  <= '0;
      out_beats_q <= '0;
      rd_cnt      <= '0;
      sent_cnt    <= '0;
      cap_cnt     <= '0;
      rd_pend     <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      sticky_done <= 1'b0;
      to_cnt      <= '0;
      status_done <= 1'b0;
      status_err  <= 1'b0;
    end else begin
      state   <= state_n;
      rd_pend <= rd_en;
      if ((state == IDLE) && start) begin
        in_beats_q  <= in_beats;
        out_beats_q <= out_beats;
        rd_cnt      <= '0;
        sent_cnt    <= '0;
        cap_cnt     <= '0;
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
        occ         <= 2'd0;
        sticky_done <= 1'b0;
        to_cnt      <= '0;
        status_done <= 1'b0;
        status_err  <= 1'b0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + CNT_W'(1);
        if (pop)   sent_cnt <= sent_cnt + CNT_W'(1);
        if (wr_en) cap_cnt <= cap_cnt + CNT_W'(1);
        // An abort flushes the FIFO; a late in-flight read is dropped in FIN.
        if (abort) begin
          occ    <= 2'd0;
          wr_ptr <= 1'b0;
          rd_ptr <= 1'b0;
        end else begin
          if (push) wr_ptr <= ~wr_ptr;
          if (pop)  rd_ptr <= ~rd_ptr;
          case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
          endcase
        end
        if (active && done) sticky_done <= 1'b1;
        if (active) to_cnt <= (pop || wr_en) ? '0 : to_cnt + TO_W'(1);
        if ((state_n == FIN) && (state != FIN)) begin
          status_done <= !abort;
          status_err  <= abort;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rd_data;
  end

endmodule

// File: tb/tb_dsp_stream_driver.sv
// Self-checking bench for dsp_stream_driver: directed runs against a
// transaction-level model of the operand stream and result capture.
module tb_dsp_stream_driver;

  localparam int BW = 2, CNT_W = 16, WORD_W = 16, DW = 32, TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst, start, in_ready, out_valid, done, err;
  logic [CNT_W-1:0] in_beats, out_beats, rd_addr, wr_addr;
  logic busy, finish, status_done, status_err, rd_en, wr_en, in_valid, out_ready;
  logic [DW-1:0] rd_data, wr_data, in_stream, out_stream;

  dsp_stream_driver #(.BW(BW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_beats(in_beats), .out_beats(out_beats),
    .busy(busy), .finish(finish), .status_done(status_done), .status_err(status_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .in_valid(in_valid), .in_stream(in_stream), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .out_stream(out_stream),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passes = 0;

  // Operand buffer contents and slave result contents, by beat index
  function automatic logic [DW-1:0] op_word(input int i);
    return {16'hA000 + 16'(i), 16'h5000 + 16'(7 * i)};
  endfunction

  function automatic logic [DW-1:0] res_word(input int k);
    return {16'hC000 + 16'(k), 16'h3000 + 16'(3 * k)};
  endfunction

  // Operand buffer with one cycle of read latency
  always @(posedge clk) rd_data <= rd_en ? op_word(int'(rd_addr)) : '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model state for the current run
  int exp_in, exp_out, rd_seen, pop_seen, wr_seen, fin_seen, valid_cnt;
  int start_cyc, first_rd_cyc, first_valid_cyc, last_valid_cyc, fin_cyc, done_cyc;
  logic [DW-1:0] first_stream, prev_stream;
  logic [DW-1:0] wr_log [8];
  logic fin_done, fin_err, prev_valid, prev_ready, prev_finish;
  bit run_done;

  // Compare process: every cycle, DUT outputs against the stream rules
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  = 1'b0;
      prev_finish = 1'b0;
    end else begin
      if (rd_en) begin
        checkOutput("rd_addr", 64'(rd_addr), 64'(rd_seen));
        checkOutput("rd_in_range", 64'(rd_seen < exp_in), 64'(1));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_seen++;
      end
      if (in_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_stream    = in_stream;
        end
        last_valid_cyc = cyc;
      end
      if (prev_valid && !prev_ready && !finish) begin
        checkOutput("hold_valid", 64'(in_valid), 64'(1));
        checkOutput("hold_stream", 64'(in_stream), 64'(prev_stream));
      end
      if (in_valid && in_ready) begin
        checkOutput("in_stream_order", 64'(in_stream), 64'(op_word(pop_seen)));
        pop_seen++;
      end
      if (busy) begin
        checkOutput("fifo_occupancy", 64'((rd_seen - pop_seen) <= 2), 64'(1));
        checkOutput("out_ready", 64'(out_ready), 64'(wr_seen < exp_out));
      end
      if (wr_en) begin
        checkOutput("wr_handshake", 64'(out_valid && out_ready), 64'(1));
        checkOutput("wr_addr", 64'(wr_addr), 64'(wr_seen));
        checkOutput("wr_data", 64'(wr_data), 64'(res_word(wr_seen)));
        checkOutput("wr_in_range", 64'(wr_seen < exp_out), 64'(1));
        wr_log[wr_seen % 8] = wr_data;
        wr_seen++;
      end
      if (finish) begin
        checkOutput("finish_one_cycle", 64'(prev_finish), 64'(0));
        checkOutput("busy_at_finish", 64'(busy), 64'(0));
        fin_seen++;
      end
      prev_valid  = in_valid;
      prev_ready  = in_ready;
      prev_stream = in_stream;
      prev_finish = finish;
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_finish"}, 64'(finish), 64'(0));
    checkOutput({tag, "_status"}, 64'({status_done, status_err}), 64'(0));
    checkOutput({tag, "_strobes"}, 64'({rd_en, wr_en, in_valid, out_ready}), 64'(0));
    checkOutput({tag, "_buses"}, 64'(in_stream | wr_data), 64'(0));
    checkOutput({tag, "_addrs"}, 64'({rd_addr, wr_addr}), 64'(0));
  endtask

  task automatic beginRun(input int ib, input int ob);
    exp_in = ib; exp_out = ob;
    rd_seen = 0; pop_seen = 0; wr_seen = 0; fin_seen = 0; valid_cnt = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
    fin_cyc = -1; done_cyc = -1; run_done = 0;
    @(posedge clk); #1;
    in_beats = CNT_W'(ib); out_beats = CNT_W'(ob); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic driveReady(input int mode);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int n = 0;
    while (!run_done && n < 300) begin
      @(posedge clk); #1;
      in_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 6] : 1'b0;
      n++;
    end
    in_ready = 1'b0;
  endtask

  // Slave result side: offers n_offer beats, gives up on refused surplus beats, then pulses done
  task automatic driveSlave(input int n_offer, input int first_delay, input int done_delay,
                            input bit check_throttle);
    int k = 0, tries = 0, stall = 0;
    repeat (first_delay) @(posedge clk);
    while (k < n_offer && tries < 60 && stall < 2) begin
      @(posedge clk); #1;
      out_valid  = 1'b1;
      out_stream = res_word(k);
      @(negedge clk);
      if (check_throttle && k >= exp_out) checkOutput("throttle_ready_low", 64'(out_ready), 64'(0));
      if (out_ready) k++;
      else if (k >= exp_out) stall++;
      tries++;
    end
    checkOutput("slave_budget", 64'(tries < 60), 64'(1));
    @(posedge clk); #1;
    out_valid = 1'b0;
    repeat (done_delay) @(posedge clk);
    #1 done = 1'b1; done_cyc = cyc;
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic waitFinish(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!finish && n < budget);
    checkOutput("finish_seen", 64'(finish), 64'(1));
    fin_cyc  = cyc;
    fin_done = status_done;
    fin_err  = status_err;
    run_done = 1;
  endtask

  task automatic applyStimulus();
    int n;
    rst = 1'b1; start = 1'b0; in_ready = 1'b0; out_valid = 1'b0; done = 1'b0; err = 1'b0;
    in_beats = '0; out_beats = '0; out_stream = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] back-to-back run");
    beginRun(4, 2);
    fork
      driveReady(0);
      driveSlave(2, 2, 1, 0);
      waitFinish(100);
    join
    #1;
    checkOutput("b2b_first_rd", 64'(first_rd_cyc), 64'(start_cyc + 1));
    checkOutput("b2b_first_valid", 64'(first_valid_cyc), 64'(start_cyc + 3));
    checkOutput("b2b_valid_cycles", 64'(valid_cnt), 64'(4));
    checkOutput("b2b_valid_span", 64'(last_valid_cyc - first_valid_cyc), 64'(3));
    checkOutput("b2b_first_beat", 64'(first_stream), 64'h0000_0000_A000_5000);
    checkOutput("b2b_result1", 64'(wr_log[1]), 64'h0000_0000_C001_3003);
    checkOutput("b2b_counts", 64'({16'(rd_seen), 16'(pop_seen), 16'(wr_seen)}),
                64'({16'd4, 16'd4, 16'd2}));
    checkOutput("b2b_status", 64'({fin_done, fin_err}), 64'(2'b10));
    @(negedge clk);
    checkOutput("b2b_status_held", 64'(status_done), 64'(1));
    checkOutput("b2b_one_finish", 64'(fin_seen), 64'(1));
    repeat (2) @(posedge clk);

    $display("[TB] backpressure run");
    beginRun(4, 2);
    fork
      driveReady(1);
      driveSlave(2, 3, 2, 0);
      waitFinish(100);
    join
    #1;
    checkOutput("bp_beats", 64'(pop_seen), 64'(4));
    checkOutput("bp_writes", 64'(wr_seen), 64'(2));
    checkOutput("bp_status", 64'({fin_done, fin_err}), 64'(2'b10));
    repeat (2) @(posedge clk);

    $display("[TB] output throttling run");
    beginRun(2, 2);
    fork
      driveReady(0);
      driveSlave(3, 2, 1, 1);
      waitFinish(100);
    join
    #1;
    checkOutput("thr_writes", 64'(wr_seen), 64'(2));
    checkOutput("thr_after_done", 64'(fin_cyc > done_cyc), 64'(1));
    checkOutput("thr_status", 64'({fin_done, fin_err}), 64'(2'b10));
    repeat (2) @(posedge clk);

    $display("[TB] err mid-stream run");
    beginRun(6, 2);
    fork
      driveReady(0);
      begin
        n = 0;
        while (pop_seen < 2 && n < 30) begin
          @(negedge clk); #1;
          n++;
        end
        checkOutput("err_two_beats_sent", 64'(pop_seen >= 2), 64'(1));
        @(posedge clk); #1 err = 1'b1;
        @(posedge clk); #1 err = 1'b0;
        @(negedge clk);
        checkOutput("err_valid_drop", 64'(in_valid), 64'(0));
        checkOutput("err_out_ready_drop", 64'(out_ready), 64'(0));
        checkOutput("err_finish", 64'(finish), 64'(1));
        checkOutput("err_status", 64'({status_done, status_err}), 64'(2'b01));
        run_done = 1;
      end
    join
    #1;
    checkOutput("err_one_finish", 64'(fin_seen), 64'(1));
    repeat (2) @(posedge clk);

    $display("[TB] timeout run");
    in_ready = 1'b0;
    beginRun(3, 0);
    waitFinish(40);
    #1;
    checkOutput("to_not_early", 64'(fin_cyc >= start_cyc + 9), 64'(1));
    checkOutput("to_not_late", 64'(fin_cyc <= start_cyc + 11), 64'(1));
    checkOutput("to_status", 64'({fin_done, fin_err}), 64'(2'b01));
    checkOutput("to_no_beats", 64'(pop_seen), 64'(0));
    repeat (2) @(posedge clk);

    $display("[TB] empty run");
    beginRun(0, 0);
    repeat (4) @(posedge clk);
    #1 done = 1'b1; done_cyc = cyc;
    @(posedge clk); #1 done = 1'b0;
    waitFinish(20);
    #1;
    checkOutput("empty_done_at_T5", 64'(done_cyc), 64'(start_cyc + 5));
    checkOutput("empty_after_done", 64'(fin_cyc >= start_cyc + 6), 64'(1));
    checkOutput("empty_prompt", 64'(fin_cyc <= start_cyc + 8), 64'(1));
    checkOutput("empty_no_strobes", 64'({16'(rd_seen), 16'(wr_seen)}), 64'(0));
    checkOutput("empty_status", 64'({fin_done, fin_err}), 64'(2'b10));
    repeat (2) @(posedge clk);

    $display("[TB] reset mid-run, then restart");
    in_ready = 1'b0;
    beginRun(4, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midreset");
    repeat (6) @(negedge clk);
    checkOutput("midreset_no_finish", 64'(fin_seen), 64'(0));
    beginRun(3, 1);
    fork
      driveReady(0);
      driveSlave(1, 3, 1, 0);
      begin
        @(posedge clk); #1;
        in_beats = CNT_W'(5); out_beats = CNT_W'(3); start = 1'b1;
        @(negedge clk);
        checkOutput("ignored_start_busy", 64'(busy), 64'(1));
        @(posedge clk); #1 start = 1'b0;
      end
      waitFinish(100);
    join
    #1;
    checkOutput("restart_counts", 64'({16'(rd_seen), 16'(pop_seen), 16'(wr_seen)}),
                64'({16'd3, 16'd3, 16'd1}));
    checkOutput("restart_status", 64'({fin_done, fin_err}), 64'(2'b10));
    checkOutput("restart_one_finish", 64'(fin_seen), 64'(1));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dsp_stream_driver.md
Name: dsp_stream_driver

Overview:
- Master-end controller for the systolic-array AXI-Stream link. Drives the master modport of AXI_STREAM_if (in_valid, in_stream, out_ready) and observes the slave's in_ready, out_valid, out_stream, done and err.
- Reads a programmed number of BW-word operand beats from a 1-cycle-latency buffer and streams them into the array.
- At the same time, captures the expected number of result beats into a result buffer.
- Reports completion or error to the host sequencer.

Parameters:
- BW, 2, words per stream beat; must match AXI_STREAM_if BW.
- CNT_W, 16, width of beat counters and buffer addresses.
- TIMEOUT, 1024, idle cycles without any accepted beat before the error is raised (0 disables the timeout).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle start pulse; ignored unless idle
- in_beats  in  CNT_W  operand beats to send; sampled at start
- out_beats  in  CNT_W  result beats to capture; sampled at start
- busy  out  1  high from the cycle after an accepted start until finish
- finish  out  1  one-cycle pulse when the run ends
- status_done  out  1  run completed cleanly; held until next start
- status_err  out  1  run aborted; held until next start
- rd_en  out  1  operand buffer read strobe
- rd_addr  out  CNT_W  operand beat address
- rd_data  in  BW*word_t  operand beat; valid 1 cycle after rd_en
- wr_en  out  1  result buffer write strobe
- wr_addr  out  CNT_W  result beat address
- wr_data  out  BW*word_t  result beat
- in_valid, in_stream, out_ready  out  1/BW*word_t/1  master modport outputs
- in_ready, out_valid, out_stream, done, err  in  1/1/BW*word_t/1/1  master modport inputs

Behaviour:
- All logic runs on clk; reset is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; counters, FIFO and the sticky bit cleared. Reset mid-run aborts immediately with no finish pulse, and in_valid drops in the next cycle.
- FSM states: IDLE, STREAM, DRAIN, FIN.
- IDLE -> STREAM on start:
  - Latches in_beats/out_beats.
  - Clears counters, status bits and the sticky done.
- STREAM:
  - Issues operand reads; rd_addr = send-issue count, 0..in_beats-1.
  - Read data enters a 2-entry FIFO. in_valid = FIFO non-empty; in_stream = FIFO head.
  - A beat transfers when in_valid & in_ready. in_stream is stable while in_valid is high and in_ready is low.
  - A read is issued when reads issued < in_beats and (occupancy + in-flight − pop this cycle) < 2. This sustains 1 beat/cycle while in_ready is held high and never overflows the FIFO.
- Output side (STREAM and DRAIN):
  - out_ready = 1 while captured < out_beats.
  - On out_valid & out_ready: wr_en=1, wr_addr = captured count, wr_data = out_stream, count++.
  - Beats beyond out_beats are never accepted.
- STREAM -> DRAIN once sent == in_beats.
- Done tracking: done high in any active state sets the sticky done bit.
- DRAIN -> FIN when captured == out_beats and sticky done is set.
- Error: err high in STREAM/DRAIN, or the timeout counter reaching TIMEOUT, goes to FIN with status_err=1.
  - The timeout counter resets on any transferred beat.
  - An error aborts: in_valid=0, out_ready=0, FIFO flushed.
- FIN:
  - finish=1 for one cycle; status_done=1 unless error.
  - busy=0 from FIN onward; FIN -> IDLE next cycle.
- Start latency: start at T -> busy and rd_en at T+1 (rd_addr 0) -> FIFO write at T+2 -> in_valid at T+3.
- in_beats=0: no reads, STREAM -> DRAIN immediately.
- in_beats=0 and out_beats=0: completes as soon as done is seen.
- start while busy: ignored, no state change.
- Simultaneous events:
  - err and final done in the same cycle: error wins.
  - FIFO push and pop in the same cycle: occupancy unchanged.
- Counters are CNT_W wide; in_beats/out_beats up to 2^CNT_W−1, no wrap.

Test Plan:
- Back-to-back run: BW=2, in_beats=4, out_beats=2, in_ready=1; slave returns 2 beats then done. Required:
  - in_valid at T+3 for exactly 4 consecutive cycles, rd_addr 0..3.
  - wr_addr 0,1 written with the slave data.
  - finish pulse, status_done=1, status_err=0.
- Backpressure: in_ready toggles 1,0,0,1,0,1…. Required:
  - in_stream holds while stalled.
  - All 4 beats arrive in order with no duplicates.
  - FIFO occupancy never exceeds 2.
- Output throttling: slave offers 3 out_valid beats with out_beats=2. Required:
  - Only 2 writes; out_ready low on the 3rd beat.
  - Completes after done.
- Error paths:
  - err pulse mid-stream (after 2 beats sent) -> in_valid drops next cycle, finish pulse, status_err=1, status_done=0.
  - TIMEOUT=8 with in_ready held 0 -> status_err after 8 idle cycles.
- Boundary: in_beats=0, out_beats=0, done asserted 5 cycles after start -> no rd_en or wr_en; finish pulse after done; status_done=1.
- Reset and start handling:
  - rst asserted mid-run -> all outputs 0 the next cycle, no finish pulse.
  - A new start then completes normally.
  - A second start while busy is ignored.
